// File: rtl/frogger_pkg.sv
// Shared Frogger types and defaults: the loss-detector FSM states and timing constants.
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    LOSS    = 2'd1,
    RESPAWN = 2'd2,
    DEAD    = 2'd3
  } frog_state_e;

  localparam int DEFAULT_TURN_TICKS    = 20;
  localparam int DEFAULT_RESPAWN_TICKS = 4;

  localparam int TURN_W    = 5;
  localparam int RESPAWN_W = 4;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reload to TURN_TICKS, saturating decrement, forced clear, and an
// expiry flag that is high when the next decrement would hit zero.
module turn_timer
  import frogger_pkg::*;
#(
  parameter int TURN_TICKS = DEFAULT_TURN_TICKS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reload_i,
  input  logic              dec_i,
  input  logic              clear_i,
  output logic [TURN_W-1:0] turn_left_o,
  output logic              expire_o
);

  localparam logic [TURN_W-1:0] RELOAD_VAL = TURN_W'(TURN_TICKS);

  logic [TURN_W-1:0] turn_left_q;
  logic [TURN_W-1:0] turn_left_d;

  // Clear (game over) beats reload, reload beats decrement; decrement stops at zero.
  always_comb begin
    turn_left_d = turn_left_q;
    if (clear_i) begin
      turn_left_d = '0;
    end else if (reload_i) begin
      turn_left_d = RELOAD_VAL;
    end else if (dec_i && (turn_left_q != '0)) begin
      turn_left_d = turn_left_q - TURN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      turn_left_q <= RELOAD_VAL;
    end else begin
      turn_left_q <= turn_left_d;
    end
  end

  assign turn_left_o = turn_left_q;
  assign expire_o    = (turn_left_q == TURN_W'(1));

endmodule

// File: rtl/loss_detector.sv
// Frogger loss detector: turns collisions, timeouts and game-over into registered
// loss/respawn pulses, a freeze flag for player input, and the remaining turn time.
module loss_detector
  import frogger_pkg::*;
#(
  parameter int TURN_TICKS    = DEFAULT_TURN_TICKS,
  parameter int RESPAWN_TICKS = DEFAULT_RESPAWN_TICKS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              collision,
  input  logic              goal,
  input  logic              move,
  input  logic              game_over,
  output logic              loss,
  output logic              respawn,
  output logic              frozen,
  output logic [TURN_W-1:0] turn_left
);

  localparam logic [RESPAWN_W-1:0] RESPAWN_LOAD = RESPAWN_W'(RESPAWN_TICKS);

  frog_state_e          state_q, state_d;
  logic                 loss_q, loss_d;
  logic                 respawn_q, respawn_d;
  logic                 frozen_q, frozen_d;
  logic [RESPAWN_W-1:0] rcnt_q, rcnt_d;

  logic timer_reload;
  logic timer_dec;
  logic timer_clear;
  logic timer_expire;

  turn_timer #(
    .TURN_TICKS (TURN_TICKS)
  ) u_turn_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .reload_i    (timer_reload),
    .dec_i       (timer_dec),
    .clear_i     (timer_clear),
    .turn_left_o (turn_left),
    .expire_o    (timer_expire)
  );

  // Next state and next registered outputs; PLAY resolves simultaneous events by priority.
  always_comb begin
    state_d      = state_q;
    loss_d       = 1'b0;
    respawn_d    = 1'b0;
    frozen_d     = 1'b0;
    rcnt_d       = rcnt_q;
    timer_reload = 1'b0;
    timer_dec    = 1'b0;
    timer_clear  = 1'b0;

    case (state_q)
      PLAY: begin
        if (game_over) begin
          state_d     = DEAD;
          frozen_d    = 1'b1;
          timer_clear = 1'b1;
        end else if (collision) begin
          state_d  = LOSS;
          loss_d   = 1'b1;
          frozen_d = 1'b1;
        end else if (goal) begin
          respawn_d    = 1'b1;
          timer_reload = 1'b1;
        end else if (tick && timer_expire) begin
          state_d   = LOSS;
          loss_d    = 1'b1;
          frozen_d  = 1'b1;
          timer_dec = 1'b1;
        end else if (move) begin
          timer_reload = 1'b1;
        end else if (tick) begin
          timer_dec = 1'b1;
        end
      end

      LOSS: begin
        state_d  = RESPAWN;
        frozen_d = 1'b1;
        rcnt_d   = RESPAWN_LOAD;
      end

      RESPAWN: begin
        frozen_d = 1'b1;
        if (game_over) begin
          state_d     = DEAD;
          timer_clear = 1'b1;
        end else if (tick && (rcnt_q <= RESPAWN_W'(1))) begin
          state_d      = PLAY;
          respawn_d    = 1'b1;
          frozen_d     = 1'b0;
          rcnt_d       = '0;
          timer_reload = 1'b1;
        end else if (tick) begin
          rcnt_d = rcnt_q - RESPAWN_W'(1);
        end
      end

      DEAD: begin
        frozen_d    = 1'b1;
        timer_clear = 1'b1;
      end

      default: begin
        state_d = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PLAY;
      loss_q    <= 1'b0;
      respawn_q <= 1'b0;
      frozen_q  <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      loss_q    <= loss_d;
      respawn_q <= respawn_d;
      frozen_q  <= frozen_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign loss    = loss_q;
  assign respawn = respawn_q;
  assign frozen  = frozen_q;

endmodule

// File: tb/tb_loss_detector.sv
// Bench for loss_detector: directed vector table, hand-written corner sequences and
// randomized play, all compared against a behavioural game model.
module tb_loss_detector;

  localparam int TT = 20;
  localparam int RT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       collision = 1'b0;
  logic       goal = 1'b0;
  logic       move = 1'b0;
  logic       game_over = 1'b0;
  logic       loss;
  logic       respawn;
  logic       frozen;
  logic [4:0] turnLeft;

  always #5 clk = ~clk;

  loss_detector #(
    .TURN_TICKS    (TT),
    .RESPAWN_TICKS (RT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .collision (collision),
    .goal      (goal),
    .move      (move),
    .game_over (game_over),
    .loss      (loss),
    .respawn   (respawn),
    .frozen    (frozen),
    .turn_left (turnLeft)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Game model: the frog is either alive, just hit, waiting out its freeze, or out of lives.
  bit mDead;
  bit mJustHit;
  bit mWaiting;
  int mFreezeLeft;
  int mTurn;
  bit mLoss;
  bit mRespawn;
  bit mFrozen;

  function automatic void modelReset();
    mDead = 0; mJustHit = 0; mWaiting = 0; mFreezeLeft = 0;
    mTurn = TT; mLoss = 0; mRespawn = 0; mFrozen = 0;
  endfunction

  function automatic void modelLoseLife();
    mJustHit = 1; mLoss = 1; mFrozen = 1;
  endfunction

  function automatic void modelStep(input bit t, input bit c, input bit g, input bit m, input bit go);
    mLoss = 0;
    mRespawn = 0;
    if (mDead) begin
      mFrozen = 1; mTurn = 0;
    end else if (mJustHit) begin
      mJustHit = 0; mWaiting = 1; mFreezeLeft = RT; mFrozen = 1;
    end else if (mWaiting) begin
      mFrozen = 1;
      if (go) begin
        mDead = 1; mWaiting = 0; mTurn = 0;
      end else if (t) begin
        mFreezeLeft = mFreezeLeft - 1;
        if (mFreezeLeft == 0) begin
          mWaiting = 0; mRespawn = 1; mTurn = TT; mFrozen = 0;
        end
      end
    end else begin
      mFrozen = 0;
      if (go) begin
        mDead = 1; mTurn = 0; mFrozen = 1;
      end else if (c) begin
        modelLoseLife();
      end else if (g) begin
        mRespawn = 1; mTurn = TT;
      end else if (t && mTurn == 1) begin
        mTurn = 0;
        modelLoseLife();
      end else if (m) begin
        mTurn = TT;
      end else if (t && mTurn > 0) begin
        mTurn = mTurn - 1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " loss"}, int'(loss), int'(mLoss));
    checkOutput({tag, " respawn"}, int'(respawn), int'(mRespawn));
    checkOutput({tag, " frozen"}, int'(frozen), int'(mFrozen));
    checkOutput({tag, " turn_left"}, int'(turnLeft), mTurn);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next fall.
  task automatic applyStimulus(input bit t, input bit c, input bit g, input bit m, input bit go,
                               input string tag);
    tick = t; collision = c; goal = g; move = m; game_over = go;
    @(posedge clk);
    modelStep(t, c, g, m, go);
    @(negedge clk);
    checkModel(tag);
  endtask

  task automatic doReset();
    tick = 0; collision = 0; goal = 0; move = 0; game_over = 0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  typedef struct {
    bit t, c, g, m, go;
    bit eLoss, eResp, eFrozen;
    int eTurn;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lossCount;
    int respCount;
    bit prevLoss;
    // inputs t c g m go | expected loss respawn frozen turn_left
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 19};
    vecs[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 18};
    vecs[2]  = '{0, 0, 0, 1, 0,  0, 0, 0, 20};
    vecs[3]  = '{0, 0, 1, 0, 0,  0, 1, 0, 20};
    vecs[4]  = '{1, 0, 0, 1, 0,  0, 0, 0, 20};
    vecs[5]  = '{0, 1, 1, 0, 0,  1, 0, 1, 20};
    vecs[6]  = '{1, 1, 0, 0, 0,  0, 0, 1, 20};
    vecs[7]  = '{1, 0, 0, 0, 0,  0, 0, 1, 20};
    vecs[8]  = '{0, 1, 1, 1, 0,  0, 0, 1, 20};
    vecs[9]  = '{1, 0, 0, 0, 0,  0, 0, 1, 20};
    vecs[10] = '{1, 0, 0, 0, 0,  0, 0, 1, 20};
    vecs[11] = '{1, 0, 0, 0, 0,  0, 1, 0, 20};
    vecs[12] = '{1, 0, 0, 0, 0,  0, 0, 0, 19};
    vecs[13] = '{0, 0, 0, 0, 1,  0, 0, 1, 0};
    vecs[14] = '{1, 1, 0, 0, 0,  0, 0, 1, 0};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset loss", int'(loss), 0);
    checkOutput("reset respawn", int'(respawn), 0);
    checkOutput("reset frozen", int'(frozen), 0);
    checkOutput("reset turn_left", int'(turnLeft), TT);
    reset_n = 1'b1;
    modelReset();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].t, vecs[i].c, vecs[i].g, vecs[i].m, vecs[i].go, $sformatf("vec%0d model", i));
      checkOutput($sformatf("vec%0d loss", i), int'(loss), int'(vecs[i].eLoss));
      checkOutput($sformatf("vec%0d respawn", i), int'(respawn), int'(vecs[i].eResp));
      checkOutput($sformatf("vec%0d frozen", i), int'(frozen), int'(vecs[i].eFrozen));
      checkOutput($sformatf("vec%0d turn_left", i), int'(turnLeft), vecs[i].eTurn);
    end

    // Timeout after TT ticks with no move, then a full freeze.
    doReset();
    for (int i = 0; i < TT - 1; i++) applyStimulus(1, 0, 0, 0, 0, "timeout run");
    checkOutput("timeout pre turn_left", int'(turnLeft), 1);
    checkOutput("timeout pre loss", int'(loss), 0);
    applyStimulus(1, 0, 0, 0, 0, "timeout edge");
    checkOutput("timeout loss", int'(loss), 1);
    checkOutput("timeout turn_left", int'(turnLeft), 0);
    applyStimulus(1, 0, 0, 0, 0, "timeout loss state");
    checkOutput("timeout loss one cycle", int'(loss), 0);
    checkOutput("timeout respawn turn_left", int'(turnLeft), 0);
    for (int i = 0; i < RT - 1; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "timeout freeze");
      checkOutput("timeout early respawn", int'(respawn), 0);
      checkOutput("timeout freeze turn_left", int'(turnLeft), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, "timeout release");
    checkOutput("timeout respawn", int'(respawn), 1);
    checkOutput("timeout release frozen", int'(frozen), 0);
    checkOutput("timeout release turn_left", int'(turnLeft), TT);

    // Move coincident with tick at turn_left==3.
    doReset();
    for (int i = 0; i < TT - 3; i++) applyStimulus(1, 0, 0, 0, 0, "move run");
    checkOutput("move pre turn_left", int'(turnLeft), 3);
    applyStimulus(1, 0, 0, 1, 0, "move+tick");
    checkOutput("move+tick turn_left", int'(turnLeft), TT);
    checkOutput("move+tick loss", int'(loss), 0);

    // Collision held for ten cycles yields a single loss and a single respawn.
    doReset();
    lossCount = 0;
    respCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 3) == 0 && i > 0, 1, 0, 0, 0, "held collision");
      lossCount += int'(loss);
      respCount += int'(respawn);
      checkOutput("held collision frozen", int'(frozen), 1);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "held collision release");
      lossCount += int'(loss);
      respCount += int'(respawn);
    end
    checkOutput("held collision loss count", lossCount, 1);
    checkOutput("held collision respawn count", respCount, 1);
    checkOutput("held collision back in play", int'(frozen), 0);

    // game_over at respawn count 1 with tick overrides the respawn.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, "dead hit");
    applyStimulus(0, 0, 0, 0, 0, "dead loss state");
    for (int i = 0; i < RT - 1; i++) applyStimulus(1, 0, 0, 0, 0, "dead freeze");
    applyStimulus(1, 0, 0, 0, 1, "dead override");
    checkOutput("dead override respawn", int'(respawn), 0);
    checkOutput("dead override frozen", int'(frozen), 1);
    checkOutput("dead override turn_left", int'(turnLeft), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 1, 0, "dead hold");
      checkOutput("dead hold loss", int'(loss), 0);
      checkOutput("dead hold frozen", int'(frozen), 1);
    end

    // Asynchronous reset in the middle of the freeze.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, "areset hit");
    applyStimulus(0, 0, 0, 0, 0, "areset loss state");
    applyStimulus(1, 0, 0, 0, 0, "areset freeze");
    applyStimulus(1, 0, 0, 0, 0, "areset freeze");
    checkOutput("areset pre frozen", int'(frozen), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset frozen", int'(frozen), 0);
    checkOutput("areset loss", int'(loss), 0);
    checkOutput("areset respawn", int'(respawn), 0);
    checkOutput("areset turn_left", int'(turnLeft), TT);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    applyStimulus(1, 0, 0, 0, 0, "areset play");
    checkOutput("areset play turn_left", int'(turnLeft), TT - 1);

    // Randomized play against the model.
    doReset();
    prevLoss = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mDead && $urandom_range(0, 9) == 0) begin
        doReset();
        prevLoss = 0;
      end
      applyStimulus(bit'($urandom_range(0, 1)),
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 10,
                    $urandom_range(0, 199) < 1,
                    "random");
      checkOutput("random loss with respawn", int'(loss && respawn), 0);
      checkOutput("random back-to-back loss", int'(loss && prevLoss), 0);
      prevLoss = loss;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
